// File: rtl/nexys_starship_spawn_sched.sv
// rtl/nexys_starship_spawn_sched.sv - central monster-spawn scheduler feeding the four lane SMs
// Optional feature: define SPAWN_SCHED_SEED_EN to add seed_in, loaded into the LFSR at each game start.
module nexys_starship_spawn_sched #(
  parameter logic [7:0] MAX_INTERVAL = 8'd40,
  parameter logic [7:0] MIN_INTERVAL = 8'd6,
  parameter logic [7:0] STEP         = 8'd4,
  parameter logic [7:0] LEVEL_SPAWNS = 8'd5,
  parameter logic [2:0] MAX_ACTIVE   = 3'd2,
  parameter logic [7:0] ACK_TIMEOUT  = 8'd3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       timer_clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover,
  input  logic [3:0] lane_full,
`ifdef SPAWN_SCHED_SEED_EN
  input  logic [7:0] seed_in,
`endif
  output logic [3:0] spawn_req,
  output logic [2:0] level,
  output logic [7:0] spawn_count,
  output logic [4:0] sched_state
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_COOL  = 5'b00010,
    S_PICK  = 5'b00100,
    S_ISSUE = 5'b01000,
    S_HALT  = 5'b10000
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] cool_q, cool_d;
  logic [7:0] interval_q, interval_d;
  logic [7:0] ack_q, ack_d;
  logic [7:0] count_q, count_d;
  logic [3:0] req_q, req_d;
  logic [1:0] lane_q, lane_d;
  logic [2:0] level_q, level_d;

  logic       abort;
  logic       lfsr_fb;
  logic [2:0] active;
  logic [1:0] cand;
  logic [1:0] pick_lane;
  logic [7:0] count_inc;
  logic [8:0] interval_dec;
  logic [7:0] interval_next;

  assign abort         = gameover | ~play_flag;
  assign lfsr_fb       = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign count_inc     = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
  assign interval_dec  = {1'b0, interval_q} - {1'b0, STEP};
  assign interval_next = (interval_dec[8] || (interval_dec[7:0] < MIN_INTERVAL)) ?
                         MIN_INTERVAL : interval_dec[7:0];

  always_comb begin
    active = 3'd0;
    for (int i = 0; i < 4; i++) active = active + {2'b00, lane_full[i]};
  end

  // Walk downward so the empty lane closest to the LFSR start index wins.
  always_comb begin
    cand      = 2'd0;
    pick_lane = lfsr_q[1:0];
    for (int k = 3; k >= 0; k--) begin
      cand = lfsr_q[1:0] + 2'(k);
      if (!lane_full[cand]) pick_lane = cand;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cool_d     = cool_q;
    interval_d = interval_q;
    ack_d      = ack_q;
    count_d    = count_q;
    req_d      = req_q;
    lane_d     = lane_q;
    level_d    = level_q;
    if (state_q != S_IDLE && state_q != S_HALT) lfsr_d = {lfsr_q[6:0], lfsr_fb};
    if ((state_q == S_COOL || state_q == S_PICK || state_q == S_ISSUE) && abort) begin
      state_d = S_HALT;
      req_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d = 4'd0;
          if (play_flag && !gameover) begin
            state_d    = S_COOL;
            cool_d     = 8'd0;
            level_d    = 3'd0;
            count_d    = 8'd0;
            interval_d = MAX_INTERVAL;
`ifdef SPAWN_SCHED_SEED_EN
            lfsr_d     = (seed_in != 8'd0) ? seed_in : LFSR_SEED;
`endif
          end
        end
        S_COOL: begin
          if (cool_q == interval_q - 8'd1) begin
            state_d = S_PICK;
            cool_d  = 8'd0;
          end else begin
            cool_d  = cool_q + 8'd1;
          end
        end
        S_PICK: begin
          if (!(active >= MAX_ACTIVE || lane_full == 4'hF)) begin
            state_d = S_ISSUE;
            req_d   = 4'b0001 << pick_lane;
            lane_d  = pick_lane;
            ack_d   = 8'd0;
          end
        end
        S_ISSUE: begin
          // Acknowledge is tested first so it wins over a coincident timeout.
          if (lane_full[lane_q]) begin
            req_d   = 4'd0;
            count_d = count_inc;
            state_d = S_COOL;
            if (count_inc % LEVEL_SPAWNS == 8'd0) begin
              level_d    = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
              interval_d = interval_next;
            end
          end else if (ack_q == ACK_TIMEOUT - 8'd1) begin
            req_d   = 4'd0;
            state_d = S_COOL;
          end else begin
            ack_d   = ack_q + 8'd1;
          end
        end
        S_HALT: begin
          req_d = 4'd0;
          if (!play_flag && !gameover) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge timer_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      cool_q     <= 8'd0;
      interval_q <= MAX_INTERVAL;
      ack_q      <= 8'd0;
      count_q    <= 8'd0;
      req_q      <= 4'd0;
      lane_q     <= 2'd0;
      level_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cool_q     <= cool_d;
      interval_q <= interval_d;
      ack_q      <= ack_d;
      count_q    <= count_d;
      req_q      <= req_d;
      lane_q     <= lane_d;
      level_q    <= level_d;
    end
  end

  assign spawn_req   = req_q;
  assign level       = level_q;
  assign spawn_count = count_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// tb/tb_nexys_starship_spawn_sched.sv - bench for the spawn scheduler: vector table, directed corners, random vs model
module tb_nexys_starship_spawn_sched;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_COOL  = 5'b00010;
  localparam logic [4:0] ST_PICK  = 5'b00100;
  localparam logic [4:0] ST_ISSUE = 5'b01000;
  localparam logic [4:0] ST_HALT  = 5'b10000;

  localparam int PH_IDLE = 0, PH_COOL = 1, PH_PICK = 2, PH_ISSUE = 3, PH_HALT = 4;

  logic       timer_clk;
  logic       Reset;
  logic       play_flag;
  logic       gameover;
  logic [3:0] lane_full;
  logic [3:0] spawn_req;
  logic [2:0] level;
  logic [7:0] spawn_count;
  logic [4:0] sched_state;
`ifdef SPAWN_SCHED_SEED_EN
  logic [7:0] seed_in = 8'h3C;
`endif

  nexys_starship_spawn_sched dut (
    .timer_clk   (timer_clk),
    .Reset       (Reset),
    .play_flag   (play_flag),
    .gameover    (gameover),
    .lane_full   (lane_full),
`ifdef SPAWN_SCHED_SEED_EN
    .seed_in     (seed_in),
`endif
    .spawn_req   (spawn_req),
    .level       (level),
    .spawn_count (spawn_count),
    .sched_state (sched_state)
  );

  initial timer_clk = 1'b0;
  always #5 timer_clk = ~timer_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: phases with countdown timers, built straight from the game rules.
  int         m_phase, m_interval, m_cool_left, m_age, m_lane, m_level, m_count;
  logic [7:0] m_lfsr;
  logic [3:0] m_req;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_lfsr = 8'hA5; m_interval = 40; m_cool_left = 0;
    m_age = 0; m_lane = 0; m_level = 0; m_count = 0; m_req = 4'd0;
  endtask

  task automatic model_step(input logic play, input logic go, input logic [3:0] lf);
    logic [7:0] src;
    int         start, lane, idx;
    src = m_lfsr;
    if (m_phase != PH_IDLE && m_phase != PH_HALT) m_lfsr = lfsr_next(m_lfsr);
    if ((m_phase == PH_COOL || m_phase == PH_PICK || m_phase == PH_ISSUE) && (go || !play)) begin
      m_phase = PH_HALT;
      m_req   = 4'd0;
      return;
    end
    case (m_phase)
      PH_IDLE: if (play && !go) begin
        m_phase = PH_COOL; m_interval = 40; m_cool_left = 40; m_level = 0; m_count = 0;
`ifdef SPAWN_SCHED_SEED_EN
        m_lfsr = (seed_in != 0) ? seed_in : 8'hA5;
`endif
      end
      PH_COOL: begin
        m_cool_left--;
        if (m_cool_left == 0) m_phase = PH_PICK;
      end
      PH_PICK: if ($countones(lf) < 2 && lf != 4'hF) begin
        start = int'(src[1:0]);
        lane  = -1;
        for (int k = 0; k < 4; k++) begin
          idx = (start + k) % 4;
          if (!lf[idx] && lane < 0) lane = idx;
        end
        m_req = 4'd1 << lane; m_lane = lane; m_age = 0; m_phase = PH_ISSUE;
      end
      PH_ISSUE: begin
        if (lf[m_lane]) begin
          m_req = 4'd0;
          if (m_count < 255) m_count++;
          if (m_count % 5 == 0) begin
            if (m_level < 7) m_level++;
            m_interval = (m_interval - 4 < 6) ? 6 : m_interval - 4;
          end
          m_phase = PH_COOL; m_cool_left = m_interval;
        end else begin
          m_age++;
          if (m_age == 3) begin
            m_req = 4'd0; m_phase = PH_COOL; m_cool_left = m_interval;
          end
        end
      end
      default: begin
        m_req = 4'd0;
        if (!play && !go) m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge timer_clk);
    model_step(play_flag, gameover, lane_full);
    @(negedge timer_clk);
    chk("m_state", sched_state, 32'd1 << m_phase);
    chk("m_req", spawn_req, m_req);
    chk("m_level", level, m_level);
    chk("m_count", spawn_count, m_count);
    if (!$onehot0(spawn_req)) chk("onehot_req", spawn_req, 0);
    if (spawn_req != 4'd0) chk("req_only_in_issue", sched_state, ST_ISSUE);
  endtask

  task automatic wait_state(input string nm, input logic [4:0] st, input int bound);
    int n = 0;
    while (sched_state != st && n < bound) begin tick(); n++; end
    chk({"wait_", nm}, sched_state, st);
  endtask

  // From COOL: measure the COOL length, then acknowledge the request one tick after it appears.
  task automatic spawn_ack(output int cool_len);
    cool_len = 0;
    while (sched_state == ST_COOL && cool_len < 300) begin tick(); cool_len++; end
    wait_state("issue", ST_ISSUE, 20);
    lane_full = spawn_req;
    tick();
    lane_full = 4'd0;
  endtask

  typedef struct {
    logic       play;
    logic       gover;
    logic [3:0] lf;
    int         cycles;
    logic [4:0] st;
    logic       req_nz;
    int         cnt;
    int         lvl;
    string      name;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic g, input logic [3:0] lf, input int cyc,
                              input logic [4:0] st, input logic nz, input int cnt, input int lvl,
                              input string nm);
    vec_t v;
    v.play = p; v.gover = g; v.lf = lf; v.cycles = cyc; v.st = st;
    v.req_nz = nz; v.cnt = cnt; v.lvl = lvl; v.name = nm;
    return v;
  endfunction

  vec_t vt[9];
  int   clen;

  initial begin
    vt[0] = mk(1, 0, 4'b0000,  1, ST_COOL,  0, 0, 0, "start");
    vt[1] = mk(1, 0, 4'b0000, 39, ST_COOL,  0, 0, 0, "cool39");
    vt[2] = mk(1, 0, 4'b0000,  1, ST_PICK,  0, 0, 0, "cool_end");
    vt[3] = mk(1, 0, 4'b0000,  1, ST_ISSUE, 1, 0, 0, "issue41");
    vt[4] = mk(1, 0, 4'b0000,  2, ST_ISSUE, 1, 0, 0, "req_hold");
    vt[5] = mk(1, 0, 4'b0000,  1, ST_COOL,  0, 0, 0, "timeout");
    vt[6] = mk(1, 0, 4'b0000, 40, ST_PICK,  0, 0, 0, "cool2");
    vt[7] = mk(1, 0, 4'b0011,  4, ST_PICK,  0, 0, 0, "occupancy");
    vt[8] = mk(1, 0, 4'b0111,  2, ST_PICK,  0, 0, 0, "occupancy3");

    Reset = 1'b1; play_flag = 1'b0; gameover = 1'b0; lane_full = 4'd0;
    model_reset();
    repeat (2) @(negedge timer_clk);
    chk("rst_state", sched_state, ST_IDLE);
    chk("rst_req", spawn_req, 4'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_count", spawn_count, 8'd0);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      play_flag = vt[i].play; gameover = vt[i].gover; lane_full = vt[i].lf;
      repeat (vt[i].cycles) tick();
      chk({vt[i].name, "_state"}, sched_state, vt[i].st);
      chk({vt[i].name, "_reqnz"}, spawn_req != 4'd0, vt[i].req_nz);
      chk({vt[i].name, "_count"}, spawn_count, vt[i].cnt);
      chk({vt[i].name, "_level"}, level, vt[i].lvl);
    end

    // Lane 0 frees up: the request must avoid the still-full lane 1.
    lane_full = 4'b0010;
    tick();
    chk("occ_issue", sched_state, ST_ISSUE);
    chk("occ_not_lane1", spawn_req[1], 1'b0);
    chk("occ_reqnz", spawn_req != 4'd0, 1'b1);
    lane_full = 4'b0010 | spawn_req;
    tick();
    chk("ack_req", spawn_req, 4'd0);
    chk("ack_count", spawn_count, 8'd1);
    chk("ack_state", sched_state, ST_COOL);
    lane_full = 4'd0;

    for (int s = 2; s <= 5; s++) spawn_ack(clen);
    chk("ramp5_level", level, 3'd1);
    chk("ramp5_count", spawn_count, 8'd5);
    spawn_ack(clen);
    chk("cool_after_lvl1", clen, 36);
    for (int s = 7; s <= 45; s++) spawn_ack(clen);
    chk("ramp45_level", level, 3'd7);
    chk("ramp45_count", spawn_count, 8'd45);
    spawn_ack(clen);
    chk("cool_clamped", clen, 6);

    wait_state("abort_issue", ST_ISSUE, 40);
    gameover = 1'b1;
    tick();
    chk("abort_halt", sched_state, ST_HALT);
    chk("abort_req", spawn_req, 4'd0);
    chk("abort_count", spawn_count, 8'd46);
    tick();
    chk("halt_hold", sched_state, ST_HALT);
    chk("halt_level", level, 3'd7);
    play_flag = 1'b0; gameover = 1'b0;
    tick();
    chk("halt_exit", sched_state, ST_IDLE);

    play_flag = 1'b1;
    tick();
    wait_state("rst_issue", ST_ISSUE, 60);
    #1 Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_req", spawn_req, 4'd0);
    chk("rst_mid_state", sched_state, ST_IDLE);
    chk("rst_mid_level", level, 3'd0);
    #1 Reset = 1'b0;
    #1;
    chk("rst_lfsr", dut.lfsr_q, 8'hA5);
    play_flag = 1'b0;
    @(negedge timer_clk);

    for (int c = 0; c < 4000; c++) begin
      int r;
      play_flag = ($urandom_range(0, 199) != 0);
      gameover  = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 3);
      if (spawn_req != 4'd0 && r < 2) lane_full = lane_full | spawn_req;
      else if (r == 3) lane_full = 4'($urandom) & 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
